// File: rtl/div_seq_pkg.sv
// Shared types for the divider request sequencer.
// Holds the FSM state encoding and the default operand width.
package div_seq_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider sequencer.
// Registered count; pointers wrap naturally (power-of-two depth).
module div_req_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_request_sequencer.sv
// Feeds queued signed division requests to the divider one at a time.
// Divide-by-zero is answered locally; results leave in request order.
module div_request_sequencer
  import div_seq_pkg::*;
#(
  parameter int tamanyo = DIV_W,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [tamanyo-1:0] IN_NUM,
  input  logic [tamanyo-1:0] IN_DEN,
  output logic               DIV_START,
  output logic [tamanyo-1:0] DIV_NUM,
  output logic [tamanyo-1:0] DIV_DEN,
  input  logic [tamanyo-1:0] DIV_COC,
  input  logic [tamanyo-1:0] DIV_RES,
  input  logic               DIV_DONE,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [tamanyo-1:0] OUT_COC,
  output logic [tamanyo-1:0] OUT_RES,
  output logic               OUT_DZ,
  output logic               BUSY
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t                 state;
  state_t                 state_n;
  logic                   done_q;
  logic                   done_rise;
  logic [2*tamanyo-1:0]   head;
  logic [tamanyo-1:0]     head_num;
  logic [tamanyo-1:0]     head_den;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   load_div;
  logic                   load_dz;
  logic                   load_res;

  div_req_fifo #(
    .W     (2 * tamanyo),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (IN_VALID),
    .pop   (pop),
    .din   ({IN_NUM, IN_DEN}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_num  = head[2*tamanyo-1 -: tamanyo];
  assign head_den  = head[tamanyo-1:0];
  assign IN_READY  = !fifo_full;
  assign DIV_START = (state == ISSUE);
  assign done_rise = DIV_DONE && !done_q;
  assign BUSY      = (fifo_count != '0)
                   || (state != IDLE)
                   || OUT_VALID;

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load_div = 1'b0;
    load_dz  = 1'b0;
    load_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !OUT_VALID) begin
          pop = 1'b1;
          if (head_den == '0) begin
            load_dz = 1'b1;
          end else begin
            load_div = 1'b1;
            state_n  = ISSUE;
          end
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // Only a fresh DONE edge counts; a stale high level is ignored.
        if (done_rise) begin
          load_res = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= DIV_DONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      DIV_NUM <= '0;
      DIV_DEN <= '0;
    end else if (load_div) begin
      DIV_NUM <= head_num;
      DIV_DEN <= head_den;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      OUT_VALID <= 1'b0;
      OUT_COC   <= '0;
      OUT_RES   <= '0;
      OUT_DZ    <= 1'b0;
    end else if (load_dz) begin
      OUT_VALID <= 1'b1;
      OUT_COC   <= '0;
      OUT_RES   <= head_num;
      OUT_DZ    <= 1'b1;
    end else if (load_res) begin
      OUT_VALID <= 1'b1;
      OUT_COC   <= DIV_COC;
      OUT_RES   <= DIV_RES;
      OUT_DZ    <= 1'b0;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer with a behavioural divider.
// Expected results are queued on accept and checked on consume.
module tb_div_request_sequencer;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_NUM;
  logic [31:0] IN_DEN;
  logic        DIV_START;
  logic [31:0] DIV_NUM;
  logic [31:0] DIV_DEN;
  logic [31:0] DIV_COC;
  logic [31:0] DIV_RES;
  logic        DIV_DONE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_COC;
  logic [31:0] OUT_RES;
  logic        OUT_DZ;
  logic        BUSY;

  typedef struct packed {
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[14];
  int   tests = 0;
  int   fails = 0;
  int   starts = 0;
  int   s0;
  bit   model_en = 1'b1;

  always #5 CLK = ~CLK;

  div_request_sequencer #(
    .tamanyo (32),
    .DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_NUM    (IN_NUM),
    .IN_DEN    (IN_DEN),
    .DIV_START (DIV_START),
    .DIV_NUM   (DIV_NUM),
    .DIV_DEN   (DIV_DEN),
    .DIV_COC   (DIV_COC),
    .DIV_RES   (DIV_RES),
    .DIV_DONE  (DIV_DONE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_COC   (OUT_COC),
    .OUT_RES   (OUT_RES),
    .OUT_DZ    (OUT_DZ),
    .BUSY      (BUSY)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int d, input int c,
                              input int r, input bit z);
    vec_t v;
    v.num = n;
    v.den = d;
    v.coc = c;
    v.res = r;
    v.dz  = z;
    return v;
  endfunction

  // Divider: holds DONE high until two cycles into the next op.
  initial begin : divider
    logic signed [31:0] mn;
    logic signed [31:0] md;
    int cnt;
    cnt = 0;
    mn = 0;
    md = 1;
    DIV_DONE = 1'b0;
    DIV_COC = '0;
    DIV_RES = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTn) begin
        cnt = 0;
      end else if (model_en) begin
        if (DIV_START) begin
          mn = DIV_NUM;
          md = DIV_DEN;
          cnt = LAT;
          starts++;
          chk("den_nonzero", (md == 0), 0);
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == LAT - 2) DIV_DONE = 1'b0;
          if (cnt == 0) begin
            DIV_COC = mn / md;
            DIV_RES = mn % md;
            DIV_DONE = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTn && OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got coc %0h res %0h, want none",
                 OUT_COC, OUT_RES);
      end else begin
        mon_e = q.pop_front();
        chk("out_coc", OUT_COC, mon_e.coc);
        chk("out_res", OUT_RES, mon_e.res);
        chk("out_dz", OUT_DZ, mon_e.dz);
      end
    end
  end

  task automatic send(input logic [31:0] n, input logic [31:0] d,
                      input logic [31:0] c, input logic [31:0] r,
                      input logic z);
    int t;
    exp_t e;
    t = 0;
    IN_NUM = n;
    IN_DEN = d;
    IN_VALID = 1'b1;
    while (!IN_READY && t < 300) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (!IN_READY) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    e.coc = c;
    e.res = r;
    e.dz = z;
    q.push_back(e);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic sendv(input vec_t v);
    send(v.num, v.den, v.coc, v.res, v.dz);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q.size() != 0 || BUSY) && t < 500) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk({nm, "_queue_left"}, q.size(), 0);
    chk({nm, "_busy"}, BUSY, 0);
    chk({nm, "_in_ready"}, IN_READY, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0;
    IN_VALID = 1'b0;
    IN_NUM = '0;
    IN_DEN = '0;
    OUT_READY = 1'b0;

    tbl[0]  = mk(4, 2, 2, 0, 0);
    tbl[1]  = mk(4, 2, 2, 0, 0);
    tbl[2]  = mk(4, -2, -2, 0, 0);
    tbl[3]  = mk(-4, 2, -2, 0, 0);
    tbl[4]  = mk(-4, -2, 2, 0, 0);
    tbl[5]  = mk(7, 0, 0, 7, 1);
    tbl[6]  = mk(100, 7, 14, 2, 0);
    tbl[7]  = mk(-100, 7, -14, -2, 0);
    tbl[8]  = mk(9, 0, 0, 9, 1);
    tbl[9]  = mk(50, -3, -16, 2, 0);
    tbl[10] = mk(-7, -2, 3, -1, 0);
    tbl[11] = mk(13, 4, 3, 1, 0);
    tbl[12] = mk(9, 3, 3, 0, 0);
    tbl[13] = mk(1000, -33, -30, 10, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_start", DIV_START, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_dz", OUT_DZ, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_div_num", DIV_NUM, 0);
    chk("rst_div_den", DIV_DEN, 0);
    chk("rst_out_coc", OUT_COC, 0);
    chk("rst_out_res", OUT_RES, 0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // single request, issue timing
    s0 = starts;
    OUT_READY = 1'b1;
    sendv(tbl[0]);
    chk("single_start_early", DIV_START, 0);
    @(posedge CLK);
    #1;
    chk("single_start", DIV_START, 1);
    chk("single_div_num", DIV_NUM, 4);
    chk("single_div_den", DIV_DEN, 2);
    @(posedge CLK);
    #1;
    chk("single_start_low", DIV_START, 0);
    drain("single");
    chk("single_starts", starts - s0, 1);

    // signed burst
    s0 = starts;
    for (int i = 1; i <= 4; i++) sendv(tbl[i]);
    drain("burst");
    chk("burst_starts", starts - s0, 4);

    // divide by zero
    s0 = starts;
    OUT_READY = 1'b0;
    sendv(tbl[5]);
    chk("dz_valid_early", OUT_VALID, 0);
    @(posedge CLK);
    #1;
    chk("dz_valid", OUT_VALID, 1);
    chk("dz_coc", OUT_COC, 0);
    chk("dz_res", OUT_RES, 7);
    chk("dz_flag", OUT_DZ, 1);
    chk("dz_no_start", DIV_START, 0);
    OUT_READY = 1'b1;
    drain("dz");
    chk("dz_starts", starts - s0, 0);

    // backpressure with six requests
    OUT_READY = 1'b0;
    s0 = starts;
    fork
      begin
        for (int i = 6; i < 12; i++) sendv(tbl[i]);
      end
      begin
        int t;
        t = 0;
        while (!OUT_VALID && t < 100) begin
          @(posedge CLK);
          #1;
          t++;
        end
        repeat (12) begin
          chk("hold_valid", OUT_VALID, 1);
          chk("hold_coc", OUT_COC, tbl[6].coc);
          chk("hold_res", OUT_RES, tbl[6].res);
          @(posedge CLK);
          #1;
        end
        chk("hold_one_start", starts - s0, 1);
        chk("full_in_ready", IN_READY, 0);
        OUT_READY = 1'b1;
      end
    join
    drain("backpressure");

    // pointer wrap-around
    s0 = starts;
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 10; i++) begin
        int n;
        int d;
        n = i * 37 - 100;
        d = (i % 5) - 2;
        if (d == 0) begin
          send(n, d, 0, n, 1);
        end else begin
          nz++;
          send(n, d, n / d, n % d, 0);
        end
      end
      drain("wrap");
      chk("wrap_starts", starts - s0, nz);
    end

    // reset while waiting on the divider
    sendv(tbl[12]);
    @(posedge CLK);
    #1;
    chk("rstw_start", DIV_START, 1);
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    q.delete();
    #1;
    chk("rstw_out_valid", OUT_VALID, 0);
    chk("rstw_start_low", DIV_START, 0);
    chk("rstw_busy", BUSY, 0);
    chk("rstw_in_ready", IN_READY, 1);
    chk("rstw_div_num", DIV_NUM, 0);
    chk("rstw_div_den", DIV_DEN, 0);
    chk("rstw_out_coc", OUT_COC, 0);
    chk("rstw_out_res", OUT_RES, 0);
    @(posedge CLK);
    #1;
    model_en = 1'b0;
    RSTn = 1'b1;
    DIV_DONE = 1'b0;
    @(posedge CLK);
    #1;
    DIV_COC = 32'h1234;
    DIV_RES = 32'h5678;
    DIV_DONE = 1'b1;
    @(posedge CLK);
    #1;
    DIV_DONE = 1'b0;
    repeat (6) begin
      chk("rstw_no_valid", OUT_VALID, 0);
      @(posedge CLK);
      #1;
    end
    chk("rstw_idle", BUSY, 0);

    // recovery after reset
    model_en = 1'b1;
    sendv(tbl[13]);
    drain("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
